// File: rtl/trg_mon_snapshot.sv
`default_nettype none
// ============================================================================
// Module   : trg_mon_snapshot
// Purpose  : Trigger-monitor readout. Freezes N_WORDS live monitor words
//            (counters, mode and config registers) into a coherent shadow
//            bank. The bank is served on the register-read bus and can also
//            be streamed as a single valid/ready burst.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in           in   1           system clock
//   rst_in           in   1           asynchronous active-high reset
//   rd_in            in   1           register read strobe (level)
//   rd_addr_in       in   AW          register read address
//   snap_req_in      in   1           explicit snapshot request (pulse)
//   mon_words_in     in   N_WORDS*DW  live monitor words, word k at k*DW
//   mon_data_out     out  DW          register read data (latency 1)
//   mon_valid_out    out  1           read data valid (pulse per read)
//   stream_start_in  in   1           start a burst of the shadow bank
//   stream_ready_in  in   1           burst sink ready
//   stream_data_out  out  DW          burst data
//   stream_valid_out out  1           burst data valid
//   stream_last_out  out  1           final beat of burst
//   snap_busy_out    out  1           burst active or snapshot pending
//   snap_seq_out     out  DW          snapshot sequence number
// Address map: BASE_ADDR+k -> shadow word k, BASE_ADDR+N_WORDS -> sequence.
// Burst order: beat 0 = sequence number, beat i = shadow word i-1.
// Assumes N_WORDS >= 2, AW >= $clog2(N_WORDS), BASE_ADDR+N_WORDS <= 2**AW-1.
// ============================================================================
module trg_mon_snapshot #(
  parameter int             N_WORDS   = 35,
  parameter int             DW        = 16,
  parameter int             AW        = 8,
  parameter logic [AW-1:0]  BASE_ADDR = 8'h19
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rd_in,
  input  logic [AW-1:0]           rd_addr_in,
  input  logic                    snap_req_in,
  input  logic [N_WORDS*DW-1:0]   mon_words_in,
  output logic [DW-1:0]           mon_data_out,
  output logic                    mon_valid_out,
  input  logic                    stream_start_in,
  input  logic                    stream_ready_in,
  output logic [DW-1:0]           stream_data_out,
  output logic                    stream_valid_out,
  output logic                    stream_last_out,
  output logic                    snap_busy_out,
  output logic [DW-1:0]           snap_seq_out
);

  localparam int IW = $clog2(N_WORDS + 1);
  localparam int SW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [AW-1:0] c_seq_addr = AW'(BASE_ADDR + N_WORDS);
  localparam logic [AW-1:0] c_n_words  = AW'(N_WORDS);
  localparam logic [IW-1:0] c_last_idx = IW'(N_WORDS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_next;
  logic            r_pending;
  logic            w_pending_next;
  logic            r_rd_q;
  logic [DW-1:0]   r_seq;
  logic [DW-1:0]   w_seq_next;
  logic [DW-1:0]   r_shadow [N_WORDS];

  logic            w_trig;
  logic            w_capture;
  logic            w_accept;
  logic [SW-1:0]   w_beat_idx;
  logic [DW-1:0]   w_beat_data;
  logic [AW-1:0]   w_off;
  logic            w_in_range;
  logic            w_is_seq;
  logic [SW-1:0]   w_rd_idx;

  // Snapshot trigger and capture qualification. A trigger seen during a
  // burst is only remembered; the shadow stays frozen until the burst ends.
  always_comb begin
    w_trig     = (rd_in & ~r_rd_q & (rd_addr_in == BASE_ADDR)) | snap_req_in;
    w_capture  = (r_state == ST_IDLE) & (w_trig | r_pending);
    w_seq_next = w_capture ? (r_seq + DW'(1)) : r_seq;
    w_accept   = (r_state == ST_STREAM) & stream_ready_in;
  end

  // Stream FSM next-state logic
  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_pending_next = r_pending;

    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_pending_next = 1'b0;
        end
        if (stream_start_in) begin
          w_state_next = ST_STREAM;
          w_idx_next   = '0;
        end
      end
      ST_STREAM: begin
        if (w_trig) begin
          w_pending_next = 1'b1;
        end
        if (w_accept) begin
          if (r_idx == c_last_idx) begin
            w_state_next = ST_IDLE;
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Beat to present after this edge. Beat 0 uses the post-edge sequence
  // number so a capture coinciding with the start is reflected in beat 0.
  always_comb begin
    w_beat_idx  = SW'(w_idx_next - IW'(1));
    w_beat_data = (w_idx_next == '0) ? w_seq_next : r_shadow[w_beat_idx];
  end

  // Register-read address decode
  always_comb begin
    w_off      = rd_addr_in - BASE_ADDR;
    w_in_range = (rd_addr_in >= BASE_ADDR) && (w_off < c_n_words);
    w_is_seq   = (rd_addr_in == c_seq_addr);
    w_rd_idx   = w_off[SW-1:0];
  end

  // FSM state register and burst output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state          <= ST_IDLE;
      r_idx            <= '0;
      r_pending        <= 1'b0;
      r_rd_q           <= 1'b0;
      r_seq            <= '0;
      stream_data_out  <= '0;
      stream_valid_out <= 1'b0;
      stream_last_out  <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_idx            <= w_idx_next;
      r_pending        <= w_pending_next;
      r_rd_q           <= rd_in;
      r_seq            <= w_seq_next;
      stream_valid_out <= (w_state_next == ST_STREAM);
      stream_last_out  <= (w_state_next == ST_STREAM) && (w_idx_next == c_last_idx);
      if (w_state_next == ST_STREAM) begin
        stream_data_out <= w_beat_data;
      end
    end
  end

  // Shadow bank: every word captured on the same edge
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < N_WORDS; k++) begin
        r_shadow[k] <= '0;
      end
    end else if (w_capture) begin
      for (int k = 0; k < N_WORDS; k++) begin
        r_shadow[k] <= mon_words_in[k*DW +: DW];
      end
    end
  end

  // Register read port. When a snapshot lands on the same edge that reads
  // word 0, return the value being captured rather than the stale shadow.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mon_data_out  <= '0;
      mon_valid_out <= 1'b0;
    end else begin
      mon_valid_out <= 1'b0;
      if (rd_in) begin
        if (w_in_range) begin
          mon_valid_out <= 1'b1;
          if (w_capture && (w_off == '0)) begin
            mon_data_out <= mon_words_in[DW-1:0];
          end else begin
            mon_data_out <= r_shadow[w_rd_idx];
          end
        end else if (w_is_seq) begin
          mon_valid_out <= 1'b1;
          mon_data_out  <= r_seq;
        end
      end
    end
  end

  assign snap_busy_out = (r_state == ST_STREAM) | r_pending;
  assign snap_seq_out  = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_trg_mon_snapshot.sv
`default_nettype none
// ============================================================================
// Module   : tb_trg_mon_snapshot
// Purpose  : Directed self-checking bench for trg_mon_snapshot
//            (N_WORDS=35, BASE_ADDR=8'h19, live word k = base + k).
// Revision : 1.0 - initial release
// ============================================================================
module tb_trg_mon_snapshot;

  localparam int N  = 35;
  localparam int DW = 16;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rd = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic            snap_req = 1'b0;
  logic [N*DW-1:0] live = '0;
  logic            start = 1'b0;
  logic            ready = 1'b0;

  logic [DW-1:0]   mon_data;
  logic            mon_valid;
  logic [DW-1:0]   sdata;
  logic            svalid;
  logic            slast;
  logic            busy;
  logic [DW-1:0]   seq;

  int n_tests = 0;
  int n_fail  = 0;

  trg_mon_snapshot #(
    .N_WORDS   (N),
    .DW        (DW),
    .AW        (AW),
    .BASE_ADDR (8'h19)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .rd_in            (rd),
    .rd_addr_in       (addr),
    .snap_req_in      (snap_req),
    .mon_words_in     (live),
    .mon_data_out     (mon_data),
    .mon_valid_out    (mon_valid),
    .stream_start_in  (start),
    .stream_ready_in  (ready),
    .stream_data_out  (sdata),
    .stream_valid_out (svalid),
    .stream_last_out  (slast),
    .snap_busy_out    (busy),
    .snap_seq_out     (seq)
  );

  always #10 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_live(input logic [15:0] base);
    for (int k = 0; k < N; k++) begin
      live[k*DW +: DW] = base + 16'(k);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int b;
    int c;
    logic [15:0] exp_beat;

    set_live(16'h1000);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_seq", 32'(seq), 32'h0);
    chk("rst_mon_valid", 32'(mon_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_svalid", 32'(svalid), 32'h0);

    // Read of a non-base word does not trigger; shadow is still zero
    rd = 1'b1; addr = 8'h1A;
    tick();
    chk("rd_1a_reset", 32'(mon_data), 32'h0);
    chk("rd_1a_reset_valid", 32'(mon_valid), 32'h1);
    chk("rd_1a_no_trig_seq", 32'(seq), 32'h0);
    rd = 1'b0;
    tick();

    // Read edge at base: snapshot with bypass of live word 0
    rd = 1'b1; addr = 8'h19;
    tick();
    chk("base_bypass_data", 32'(mon_data), 32'h1000);
    chk("base_valid", 32'(mon_valid), 32'h1);
    chk("base_seq", 32'(seq), 32'h1);
    rd = 1'b0;
    tick();
    set_live(16'h2000);
    rd = 1'b1; addr = 8'h1A;
    tick();
    chk("shadow_word1", 32'(mon_data), 32'h1001);

    // Sequence address, then out-of-range addresses
    addr = 8'h3C;
    tick();
    chk("seq_addr_data", 32'(mon_data), 32'h1);
    chk("seq_addr_valid", 32'(mon_valid), 32'h1);
    addr = 8'h3D;
    tick();
    chk("addr_3d_hold", 32'(mon_data), 32'h1);
    chk("addr_3d_valid", 32'(mon_valid), 32'h0);
    addr = 8'h18;
    tick();
    chk("addr_18_hold", 32'(mon_data), 32'h1);
    chk("addr_18_valid", 32'(mon_valid), 32'h0);
    rd = 1'b0;
    tick();
    chk("rd_low_valid", 32'(mon_valid), 32'h0);
    chk("rd_low_hold", 32'(mon_data), 32'h1);

    // Burst with ready toggling; snapshot request at beat 10
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("stream_busy", 32'(busy), 32'h1);
    b = 0;
    c = 0;
    while (b <= 35 && c < 200) begin
      exp_beat = (b == 0) ? 16'h0001 : 16'(16'h1000 + b - 1);
      chk("stream_valid", 32'(svalid), 32'h1);
      chk("stream_data", 32'(sdata), 32'(exp_beat));
      chk("stream_last", 32'(slast), 32'(b == 35));
      chk("stream_busy_beat", 32'(busy), 32'h1);
      ready    = (c % 2 == 0);
      snap_req = (b == 10) && (c % 2 == 0);
      tick();
      snap_req = 1'b0;
      if (ready) b++;
      c++;
    end
    if (b <= 35) chk("stream_timeout", 32'(b), 32'd36);
    ready = 1'b0;

    // Burst done: pending snapshot not yet taken
    chk("post_burst_valid", 32'(svalid), 32'h0);
    chk("post_burst_last", 32'(slast), 32'h0);
    chk("post_burst_busy", 32'(busy), 32'h1);
    chk("post_burst_seq", 32'(seq), 32'h1);
    tick();
    chk("pending_capture_seq", 32'(seq), 32'h2);
    chk("pending_capture_busy", 32'(busy), 32'h0);
    rd = 1'b1; addr = 8'h1A;
    tick();
    chk("pending_capture_word1", 32'(mon_data), 32'h2001);
    rd = 1'b0;
    tick();

    // Held read at base: one snapshot only
    set_live(16'h3000);
    rd = 1'b1; addr = 8'h19;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_rd_valid", 32'(mon_valid), 32'h1);
      chk("held_rd_data", 32'(mon_data), 32'h3000);
    end
    chk("held_rd_seq", 32'(seq), 32'h3);
    rd = 1'b0;
    tick();

    // Reset mid-burst: outputs fall without a clock edge
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_burst_valid", 32'(svalid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_svalid", 32'(svalid), 32'h0);
    chk("async_rst_slast", 32'(slast), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_seq", 32'(seq), 32'h0);
    tick();
    rst = 1'b0;
    rd = 1'b1; addr = 8'h1A;
    tick();
    chk("after_rst_word1", 32'(mon_data), 32'h0);
    rd = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
